// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx                                                     |
// | Description : 8N1 asynchronous serial receiver, LSB first, idle-high     |
// |               line. Oversamples rx with clk and samples each bit at its  |
// |               centre. Each received byte is presented on data with a     |
// |               one-cycle rcv strobe.                                       |
// | Options     : UART_RX_FERR_EN - adds the ferr port. A frame whose stop  |
// |               bit reads 0 is dropped and ferr pulses instead of rcv.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

`ifndef B9600
`define B9600 1250
`endif

module uart_rx #(
  parameter int BAUDRATE = `B9600  // clk cycles per bit period, >= 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       busy
`ifdef UART_RX_FERR_EN
  ,
  output logic       ferr
`endif
);

  localparam int c_DIV_W = $clog2(BAUDRATE);
  // The first tick lands on the start-bit centre. Later ticks are one full bit apart.
  localparam logic [c_DIV_W-1:0] c_HALF = c_DIV_W'(BAUDRATE / 2 - 1);
  localparam logic [c_DIV_W-1:0] c_FULL = c_DIV_W'(BAUDRATE - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RECV = 2'd1;
  localparam logic [1:0] c_LOAD = 2'd2;
  localparam logic [1:0] c_DAV  = 2'd3;

  logic               r_rx_meta;
  logic               r_rx_s;
  logic               r_rx_prev;
  logic               w_start_edge;
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_DIV_W-1:0] r_div;
  logic [3:0]         r_bitcnt;
  logic               w_tick;
  logic [7:0]         r_shift;
  logic [7:0]         r_data;
  logic               r_rcv;
  logic               w_frame_ok;
  logic               w_busy;
  logic               w_load;
  logic               w_rcv_set;
  logic               w_ferr_set;

  // Two-flop synchroniser plus one history flop for edge detection. All reset to idle-high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_start_edge = r_rx_prev & ~r_rx_s;
  assign w_tick = (r_state == c_RECV) &&
                  (r_div == ((r_bitcnt == 4'd0) ? c_HALF : c_FULL));

`ifdef UART_RX_FERR_EN
  logic r_stop_bit;
  logic r_ferr;

  // Stop bit captured at the last sample tick. It decides whether the frame is delivered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stop_bit <= 1'b0;
    end else if (w_tick && (r_bitcnt == 4'd9)) begin
      r_stop_bit <= r_rx_s;
    end
  end

  assign w_frame_ok = r_stop_bit;
`else
  // The stop bit is sampled for timing only. Every frame with a valid start bit is delivered.
  assign w_frame_ok = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic. A start bit that reads high at its centre is a glitch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: if (w_start_edge) w_state_nxt = c_RECV;
      c_RECV: begin
        if (w_tick) begin
          if ((r_bitcnt == 4'd0) && r_rx_s) begin
            w_state_nxt = c_IDLE;
          end else if (r_bitcnt == 4'd9) begin
            w_state_nxt = c_LOAD;
          end
        end
      end
      c_LOAD:  w_state_nxt = c_DAV;
      c_DAV:   w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    w_busy     = (r_state == c_RECV) || (r_state == c_LOAD);
    w_load     = (r_state == c_LOAD) && w_frame_ok;
    w_rcv_set  = (r_state == c_DAV) && w_frame_ok;
    w_ferr_set = (r_state == c_DAV) && !w_frame_ok;
  end

  // Bit-period divider and tick counter. Both are held at zero outside RECV.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div    <= '0;
      r_bitcnt <= 4'd0;
    end else if (r_state == c_RECV) begin
      if (w_tick) begin
        r_div    <= '0;
        r_bitcnt <= r_bitcnt + 4'd1;
      end else begin
        r_div    <= r_div + 1'b1;
      end
    end else begin
      r_div    <= '0;
      r_bitcnt <= 4'd0;
    end
  end

  // Data bits enter at the MSB and move down, so the first bit received ends up in bit 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift <= 8'h00;
    end else if (w_tick && (r_bitcnt >= 4'd1) && (r_bitcnt <= 4'd8)) begin
      r_shift <= {r_rx_s, r_shift[7:1]};
    end
  end

  // Output registers. data holds its value until a good frame loads; rcv is a single-cycle strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= 8'h00;
      r_rcv  <= 1'b0;
    end else begin
      if (w_load) r_data <= r_shift;
      r_rcv <= w_rcv_set;
    end
  end

`ifdef UART_RX_FERR_EN
  // Framing-error strobe takes the rcv slot of the rejected frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ferr <= 1'b0;
    end else begin
      r_ferr <= w_ferr_set;
    end
  end

  assign ferr = r_ferr;
`else
  logic w_ferr_unused;
  assign w_ferr_unused = w_ferr_set;
`endif

  assign data = r_data;
  assign rcv  = r_rcv;
  assign busy = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_rx                                                  |
// | Description : Directed self-checking bench for uart_rx, BAUDRATE=16.     |
// |               Define UART_RX_FERR_EN to exercise the framing-error port. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_uart_rx;

  localparam int c_BAUD = 16;
  // RECV covers B/2 cycles to the start-bit tick and 9 more bit periods. LOAD adds one cycle.
  localparam int c_BUSY_FRAME = c_BAUD / 2 + 9 * c_BAUD + 1;

  logic       clk;
  logic       rstn;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       busy;
`ifdef UART_RX_FERR_EN
  logic       ferr;
`endif

  uart_rx #(.BAUDRATE(c_BAUD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .data (data),
    .rcv  (rcv),
    .busy (busy)
`ifdef UART_RX_FERR_EN
    ,
    .ferr (ferr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] rcv_q[$];
  int         rcv_total  = 0;
  int         busy_total = 0;
  int         ferr_total = 0;

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rcv) begin
      rcv_q.push_back(data);
      rcv_total++;
    end
    if (busy) busy_total++;
`ifdef UART_RX_FERR_EN
    if (ferr) ferr_total++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (c_BAUD) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    int b0;
    int f0;
    logic [7:0] c3;

    // 1. Reset state and an idle line.
    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {24'h0, data}, 32'h00);
    check("rst_rcv", {31'h0, rcv}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
`ifdef UART_RX_FERR_EN
    check("rst_ferr", {31'h0, ferr}, 32'h0);
`endif
    rstn = 1'b1;
    idle(20);
    check("idle_rcv", rcv_total, 0);
    check("idle_busy", busy_total, 0);
    check("idle_data", {24'h0, data}, 32'h00);

    // 2. A single frame, 0xA5.
    r0 = rcv_total; b0 = busy_total;
    send_byte(8'hA5, 1'b1);
    idle(10);
    check("a5_count", rcv_total - r0, 1);
    check("a5_pulse_data", {24'h0, rcv_q[r0]}, 32'hA5);
    check("a5_data_hold", {24'h0, data}, 32'hA5);
    check("a5_busy_len", busy_total - b0, c_BUSY_FRAME);
    check("a5_busy_end", {31'h0, busy}, 32'h0);

    // 3. A short low glitch is rejected at the start-bit centre.
    r0 = rcv_total; b0 = busy_total;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    check("glitch_rcv", rcv_total - r0, 0);
    check("glitch_data", {24'h0, data}, 32'hA5);
    check("glitch_busy_len", busy_total - b0, c_BAUD / 2);

    // 4. Three frames back-to-back with no idle gap.
    r0 = rcv_total; b0 = busy_total;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    idle(10);
    check("b2b_count", rcv_total - r0, 3);
    check("b2b_0", {24'h0, rcv_q[r0]}, 32'h00);
    check("b2b_1", {24'h0, rcv_q[r0+1]}, 32'hFF);
    check("b2b_2", {24'h0, rcv_q[r0+2]}, 32'h3C);
    check("b2b_busy_len", busy_total - b0, 3 * c_BUSY_FRAME);

    // 5. Stop bit reads 0.
    r0 = rcv_total; f0 = ferr_total;
    send_byte(8'h55, 1'b0);
    idle(20);
`ifdef UART_RX_FERR_EN
    check("ferr_count", ferr_total - f0, 1);
    check("ferr_rcv", rcv_total - r0, 0);
    check("ferr_data", {24'h0, data}, 32'h3C);
`else
    check("nostop_rcv", rcv_total - r0, 1);
    check("nostop_data", {24'h0, data}, 32'h55);
    check("nostop_ferr", ferr_total - f0, 0);
`endif

    // 6. Reset in the middle of data bit 4 of 0xC3, then a clean 0x81 frame.
    r0 = rcv_total;
    c3 = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c3[i]);
    rx = c3[4];
    repeat (c_BAUD / 2) @(negedge clk);
    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_data", {24'h0, data}, 32'h00);
    check("abort_busy", {31'h0, busy}, 32'h0);
    rstn = 1'b1;
    idle(20);
    check("abort_rcv", rcv_total - r0, 0);
    r0 = rcv_total;
    send_byte(8'h81, 1'b1);
    idle(10);
    check("post_count", rcv_total - r0, 1);
    check("post_pulse_data", {24'h0, rcv_q[r0]}, 32'h81);
    check("post_data", {24'h0, data}, 32'h81);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
